mem_access_stage: RTL and testbench

Memory-access stage of the 5-stage RV32I pipeline, sitting between the EX/MEM register and the MEM/WB register. It turns EX/MEM load/store control into a request/ready transaction on the data memory. It handles byte/halfword lane selection, store byte enables and load sign/zero extension, and stalls the upstream pipeline until the access completes. Non-memory instructions pass through in the same cycle.

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the memory-access stage (master) and data memory (slave).
interface mem_access_stage_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 10
);
    logic                   dmem_req;
    logic                   dmem_we;
    logic [ADDR_SIZE-3:0]   dmem_addr;
    logic [WORD_SIZE-1:0]   dmem_wdata;
    logic [3:0]             dmem_be;
    logic [WORD_SIZE-1:0]   dmem_rdata;
    logic                   dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: lane steering, load extension and stall control for a request/ready data memory.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: misaligned half/word accesses are dropped and flagged on misalign_o.
module mem_access_stage #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned REG_SEL   = $clog2(NUM_REGS),
    parameter int unsigned ADDR_SIZE = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [WORD_SIZE-1:0] alu_result_i,
    input  logic [WORD_SIZE-1:0] store_data_i,
    input  logic [2:0]           funct3_i,
    input  logic [REG_SEL-1:0]   rd_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic                 reg_write_i,
    output logic                 stall_o,
    mem_access_stage_if.master   dmem,
    output logic [WORD_SIZE-1:0] read_data_o,
    output logic [WORD_SIZE-1:0] result_o,
    output logic [REG_SEL-1:0]   rd_o,
    output logic                 mem_read_o,
    output logic                 reg_write_o,
    output logic                 misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                 state_q;
    logic                   req_q, we_q, load_q, rw_q;
    logic [ADDR_SIZE-3:0]   addr_q;
    logic [WORD_SIZE-1:0]   wdata_q, alu_q, ldata_q;
    logic [3:0]             be_q;
    logic [2:0]             f3_q;
    logic [1:0]             off_q;
    logic [REG_SEL-1:0]     rd_q;

    logic                   mem_op, is_store, is_byte, is_half, is_word, trap;
    logic [1:0]             off, eff_off;
    logic [WORD_SIZE-1:0]   wdata_d, ldata_d;
    logic [3:0]             be_d;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;

    // Store and load size decode differ: only loads treat funct3[2] as the unsigned flag.
    always_comb begin
        off      = alu_result_i[1:0];
        mem_op   = valid_i & (mem_read_i | mem_write_i);
        is_store = mem_write_i;
        if (is_store) begin
            is_byte = (funct3_i == 3'b000);
            is_half = (funct3_i == 3'b001);
        end else begin
            is_byte = (funct3_i[1:0] == 2'b00);
            is_half = (funct3_i[1:0] == 2'b01);
        end
        is_word = ~is_byte & ~is_half;
        eff_off = is_byte ? off : (is_half ? {off[1], 1'b0} : 2'b00);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        trap = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
        trap = 1'b0;
`endif
        if (is_byte) begin
            wdata_d = {4{store_data_i[7:0]}};
            be_d    = 4'b0001 << eff_off;
        end else if (is_half) begin
            wdata_d = {2{store_data_i[15:0]}};
            be_d    = 4'b0011 << eff_off;
        end else begin
            wdata_d = store_data_i;
            be_d    = 4'b1111;
        end
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ldata_d = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ldata_d = {24'b0, ld_byte};
            3'b001:  ldata_d = {{16{ld_half[15]}}, ld_half};
            3'b101:  ldata_d = {16'b0, ld_half};
            default: ldata_d = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            alu_q   <= '0;
            load_q  <= 1'b0;
            ldata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op && !trap) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= alu_result_i[ADDR_SIZE-1:2];
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        f3_q    <= funct3_i;
                        off_q   <= off;
                        rd_q    <= rd_i;
                        rw_q    <= reg_write_i;
                        alu_q   <= alu_result_i;
                        load_q  <= ~is_store;
                        ldata_q <= '0;
                    end
                end
                REQ: begin
                    if (dmem.dmem_ready) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        if (load_q) ldata_q <= ldata_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    // Outputs are forced to zero while reset is held, even though IDLE is otherwise a pass-through.
    always_comb begin
        stall_o     = 1'b0;
        result_o    = '0;
        read_data_o = '0;
        rd_o        = '0;
        mem_read_o  = 1'b0;
        reg_write_o = 1'b0;
        misalign_o  = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (mem_op && !trap) begin
                        stall_o = 1'b1;
                    end else begin
                        result_o = alu_result_i;
                        rd_o     = rd_i;
                        if (trap) begin
                            misalign_o = 1'b1;
                        end else begin
                            mem_read_o  = mem_read_i;
                            reg_write_o = reg_write_i & valid_i;
                        end
                    end
                end
                REQ: stall_o = 1'b1;
                DONE: begin
                    result_o    = alu_q;
                    read_data_o = ldata_q;
                    rd_o        = rd_q;
                    mem_read_o  = load_q;
                    reg_write_o = rw_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a behavioural data memory that inserts programmable wait cycles.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid, mem_read, mem_write, reg_write;
    logic [31:0] alu_result, store_data;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        stall, mem_read_out, reg_write_out, misalign;
    logic [31:0] read_data_out, result_out;
    logic [4:0]  rd_out;

    mem_access_stage_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) mif ();

    mem_access_stage #(
        .WORD_SIZE(32), .NUM_REGS(32), .REG_SEL(5), .ADDR_SIZE(10)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid),
        .alu_result_i(alu_result), .store_data_i(store_data), .funct3_i(funct3), .rd_i(rd),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .reg_write_i(reg_write),
        .stall_o(stall), .dmem(mif),
        .read_data_o(read_data_out), .result_o(result_out), .rd_o(rd_out),
        .mem_read_o(mem_read_out), .reg_write_o(reg_write_out), .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Behavioural memory: ready after wait_cycles negedges of an open request.
    logic [31:0] mem [0:255];
    int wait_cycles = 0;
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (mif.dmem_req) begin
            if (wait_cnt >= wait_cycles) begin
                mif.dmem_ready = 1'b1;
                mif.dmem_rdata = mem[mif.dmem_addr];
                if (mif.dmem_we)
                    for (int i = 0; i < 4; i++)
                        if (mif.dmem_be[i]) mem[mif.dmem_addr][8*i +: 8] = mif.dmem_wdata[8*i +: 8];
                wait_cnt = 0;
            end else begin
                mif.dmem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mif.dmem_ready = 1'b0;
            mif.dmem_rdata = $urandom;
            wait_cnt = 0;
        end
    end

    typedef struct {
        logic [31:0] result, rdata;
        logic [4:0]  rd;
        logic        mr, rw, mis;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] obs_rdata;

    task automatic run_op(input logic v, mr, mw, rw, input logic [2:0] f3,
                          input logic [31:0] alu, sd, input logic [4:0] rid, input int waits);
        exp_t        e;
        logic [1:0]  off;
        logic [7:0]  idx;
        logic [31:0] w, exp_wd;
        logic [3:0]  exp_be;
        logic        mem_op, trap, is_half, is_word;
        int          st;
        off     = alu[1:0];
        idx     = alu[9:2];
        mem_op  = v && (mr || mw);
        is_half = mw ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
        is_word = mw ? (f3 > 3'd1) : !(f3 inside {3'd0, 3'd1, 3'd4, 3'd5});
        trap    = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        trap = mem_op && ((is_half && off[0]) || (is_word && off != 2'd0));
`endif
        if (f3 == 3'd0) begin
            exp_wd = {4{sd[7:0]}};
            exp_be = 4'b0001 << off;
        end else if (f3 == 3'd1) begin
            exp_wd = {2{sd[15:0]}};
            exp_be = off[1] ? 4'b1100 : 4'b0011;
        end else begin
            exp_wd = sd;
            exp_be = 4'b1111;
        end
        w = mem[idx];
        case (f3)
            3'd0, 3'd4: begin
                w = (w >> (8 * off)) & 32'hFF;
                if (f3 == 3'd0 && w[7]) w = w | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                w = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
                if (f3 == 3'd1 && w[15]) w = w | 32'hFFFF_0000;
            end
            default: ;
        endcase
        e.result = alu;
        e.rd     = rid;
        if (!mem_op || trap) begin
            e.rdata = 32'd0; e.mr = trap ? 1'b0 : mr; e.rw = trap ? 1'b0 : (rw && v);
            e.mis = trap; e.stalls = 0;
        end else begin
            e.rdata = mw ? 32'd0 : w; e.mr = !mw; e.rw = rw;
            e.mis = 1'b0; e.stalls = 2 + waits;
        end

        valid = v; mem_read = mr; mem_write = mw; reg_write = rw;
        funct3 = f3; alu_result = alu; store_data = sd; rd = rid;
        wait_cycles = waits;
        sb_q.push_back(e);

        st = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!stall) break;
            if (st == 0) begin
                check_eq("req_early", {31'd0, mif.dmem_req}, 32'd0);
            end else begin
                check_eq("req_held", {31'd0, mif.dmem_req}, 32'd1);
                check_eq("addr", {24'd0, mif.dmem_addr}, {24'd0, idx});
                check_eq("we", {31'd0, mif.dmem_we}, {31'd0, mw});
                if (mw) begin
                    check_eq("wdata", mif.dmem_wdata, exp_wd);
                    check_eq("be", {28'd0, mif.dmem_be}, {28'd0, exp_be});
                end
            end
            st++;
        end

        e = sb_q.pop_front();
        check_eq("stall_cycles", st, e.stalls);
        check_eq("req_idle", {31'd0, mif.dmem_req}, 32'd0);
        check_eq("result", result_out, e.result);
        check_eq("read_data", read_data_out, e.rdata);
        check_eq("rd", {27'd0, rd_out}, {27'd0, e.rd});
        check_eq("mem_read_out", {31'd0, mem_read_out}, {31'd0, e.mr});
        check_eq("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
        check_eq("misalign", {31'd0, misalign}, {31'd0, e.mis});
        obs_rdata = read_data_out;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0080_0000;
        mem[1] = 32'h8001_0000;

        rst_ni = 1'b0;
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        funct3 = 3'd2; alu_result = 32'h0000_0123; store_data = '0; rd = 5'd3;
        #3;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_result", result_out, 32'd0);
        check_eq("rst_rd", {27'd0, rd_out}, 32'd0);
        check_eq("rst_reg_write", {31'd0, reg_write_out}, 32'd0);
        check_eq("rst_req", {31'd0, mif.dmem_req}, 32'd0);
        check_eq("rst_be", {28'd0, mif.dmem_be}, 32'd0);
        repeat (2) @(negedge clk);
        valid = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // ADD pass-through
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_0040, 32'd0, 5'd5, 0);
        // LB / LBU at 0x002, LBU with two wait cycles
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0002, 32'd0, 5'd6, 0);
        check_eq("lb_value", obs_rdata, 32'hFFFF_FF80);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_0002, 32'd0, 5'd7, 2);
        check_eq("lbu_value", obs_rdata, 32'h0000_0080);
        // LH at 0x006
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_0006, 32'd0, 5'd8, 0);
        check_eq("lh_value", obs_rdata, 32'hFFFF_8001);
        // SB at 0x003
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_0003, 32'h1234_56AB, 5'd0, 0);
        check_eq("sb_mem", mem[0], 32'hAB80_0000);
        // LW at 0x002
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_0002, 32'd0, 5'd9, 1);
`ifndef MEM_STAGE_MISALIGN_TRAP_EN
        check_eq("lw_value", obs_rdata, 32'hAB80_0000);
`endif
        // valid low with load control: no request, no register write
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'd0, 5'd10, 0);
        // read+write together acts as a store (SH upper half)
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_0006, 32'h0000_BEEF, 5'd11, 0);
        check_eq("sh_mem", mem[1], 32'hBEEF_0000);

        // Reset while a request is open
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        funct3 = 3'd2; alu_result = 32'h0000_0010; rd = 5'd7; wait_cycles = 10;
        repeat (3) @(negedge clk);
        check_eq("abort_req_open", {31'd0, mif.dmem_req}, 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("abort_req", {31'd0, mif.dmem_req}, 32'd0);
        check_eq("abort_stall", {31'd0, stall}, 32'd0);
        check_eq("abort_result", result_out, 32'd0);
        check_eq("abort_rd", {27'd0, rd_out}, 32'd0);
        check_eq("abort_mem_read", {31'd0, mem_read_out}, 32'd0);
        check_eq("abort_reg_write", {31'd0, reg_write_out}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'd0, 5'd7, 0);

        for (int n = 0; n < 16; n++) begin
            logic        r_mw;
            logic [31:0] r_alu;
            r_mw  = ($urandom_range(0, 2) == 0);
            r_alu = $urandom;
            run_op(1'b1, !r_mw, r_mw, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                   r_alu, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
